// File: rtl/multiplier_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
// Optional feature macro used by this codebase slice: MULTIPLIER_SEQ_OVF_EN.
package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_UU,
        MODE_SU,
        MODE_SS
    } mode_t;

    // Number of radix-4 digits in a SIZE+2 bit extended multiplier
    function automatic int STEPS(input int size);
        return size / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_recoder_r4.sv
// Radix-4 Booth recoder: a 3-bit multiplier window becomes a digit in
// {-2,-1,0,+1,+2}, expressed as a one-hot magnitude select plus negate.
module booth_recoder_r4 (
    input  logic [2:0] window,
    output logic       sel_one,
    output logic       sel_two,
    output logic       negate
);

    // Digit magnitude and sign from the overlapping bit triple
    always_comb begin
        sel_one = window[1] ^ window[0];
        sel_two = (window == 3'b011) | (window == 3'b100);
        negate  = window[2] & ~(window[1] & window[0]);
    end

endmodule

// File: rtl/sklansky_adder.sv
// Parallel-prefix (Sklansky) adder with carry-in and carry-out.
module sklansky_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] grp_g;
    logic [WIDTH-1:0] grp_p;
    logic [WIDTH-1:0] carry;

    // Divide-and-conquer prefix tree; the partner bit j never changes within a level
    always_comb begin
        prop  = a ^ b;
        grp_g = a & b;
        grp_p = a ^ b;
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (((i >> l) & 1) == 1) begin
                    int j;
                    j = ((i >> l) << l) - 1;
                    grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[j]);
                    grp_p[i] = grp_p[i] & grp_p[j];
                end
            end
        end
        carry[0] = cin;
        for (int i = 1; i < WIDTH; i++) begin
            carry[i] = grp_g[i-1] | (grp_p[i-1] & cin);
        end
        cout = grp_g[WIDTH-1] | (grp_p[WIDTH-1] & cin);
        sum  = prop ^ carry;
    end

endmodule

// File: rtl/multiplier_seq_msu.sv
// Sequential radix-4 Booth multiplier, unsigned / signed-unsigned / signed,
// one Booth digit per BUSY cycle with a valid/ready handshake on each side.
// Optional overflow flag output enabled by macro MULTIPLIER_SEQ_OVF_EN.
module multiplier_seq_msu
    import multiplier_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    input  logic              sign,
    input  logic              mix,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*SIZE-1:0] y,
`ifdef MULTIPLIER_SEQ_OVF_EN
    output logic              ovf,
`endif
    output logic              busy
);

    localparam int NUM_STEPS = STEPS(SIZE);
    localparam int CNT_W     = $clog2(NUM_STEPS + 1);
    localparam int EW        = SIZE + 2;

    state_t            state, state_next;
    mode_t             mode_in;
    logic              ready_en;
    logic              accept;
    logic              last_step;
    logic [CNT_W-1:0]  cnt_q;
    logic [EW-1:0]     m_q;
    logic [EW-1:0]     h_q;
    logic [EW-1:0]     l_q;
    logic              prev_q;
    logic              sel_one, sel_two, negate;
    logic [EW-1:0]     pp_mag;
    logic [EW-1:0]     pp;
    logic [EW-1:0]     add_sum;
    logic              add_cout;
    logic [EW:0]       sum_ext;
    logic [EW-1:0]     h_next;
    logic [EW-1:0]     l_next;
    logic [EW-1:0]     a_ext;
    logic [EW-1:0]     b_ext;

    booth_recoder_r4 u_recoder (
        .window  ({l_q[1:0], prev_q}),
        .sel_one (sel_one),
        .sel_two (sel_two),
        .negate  (negate)
    );

    sklansky_adder #(.WIDTH(EW)) u_adder (
        .a    (h_q),
        .b    (pp),
        .cin  (negate),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Mode decode, operand extension and one Booth step of the shift-add datapath
    always_comb begin
        mode_in = sign ? MODE_SS : (mix ? MODE_SU : MODE_UU);
        a_ext   = (mode_in != MODE_UU) ? {{2{a[SIZE-1]}}, a} : {2'b00, a};
        b_ext   = (mode_in == MODE_SS) ? {{2{b[SIZE-1]}}, b} : {2'b00, b};
        pp_mag  = '0;
        if (sel_one) begin
            pp_mag = m_q;
        end else if (sel_two) begin
            pp_mag = {m_q[EW-2:0], 1'b0};
        end
        pp      = negate ? ~pp_mag : pp_mag;
        // True sign of the EW+1 bit sum recovered from the operand MSBs and carry-out
        sum_ext = {h_q[EW-1] ^ pp[EW-1] ^ add_cout, add_sum};
        h_next  = {sum_ext[EW], sum_ext[EW:2]};
        l_next  = {sum_ext[1:0], l_q[EW-1:2]};
    end

    // Handshake qualifiers; in_ready stays low until the first edge after reset release
    always_comb begin
        last_step = (cnt_q == CNT_W'(NUM_STEPS - 1));
        in_ready  = ready_en & ((state == IDLE) | ((state == DONE) & out_ready));
        accept    = in_valid & in_ready;
        out_valid = (state == DONE);
        busy      = (state == BUSY);
    end

    // Next-state logic for the IDLE/BUSY/DONE controller
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = BUSY;
            BUSY: if (last_step) state_next = DONE;
            DONE: begin
                if (accept) begin
                    state_next = BUSY;
                end else if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready_en <= 1'b0;
        end else begin
            state    <= state_next;
            ready_en <= 1'b1;
        end
    end

    // Operand capture, per-step accumulation and result latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            m_q    <= '0;
            h_q    <= '0;
            l_q    <= '0;
            prev_q <= 1'b0;
            y      <= '0;
        end else if (accept) begin
            cnt_q  <= '0;
            m_q    <= a_ext;
            h_q    <= '0;
            l_q    <= b_ext;
            prev_q <= 1'b0;
        end else if (state == BUSY) begin
            cnt_q  <= cnt_q + 1'b1;
            h_q    <= h_next;
            l_q    <= l_next;
            prev_q <= l_q[1];
            if (last_step) begin
                y <= {h_next[SIZE-3:0], l_next};
            end
        end
    end

`ifdef MULTIPLIER_SEQ_OVF_EN
    logic signed_res_q;
    logic ovf_next;

    // Upper half must equal the extension of the lower half for the result mode
    always_comb begin
        if (signed_res_q) begin
            ovf_next = ({h_next[SIZE-3:0], l_next[EW-1:SIZE]} != {SIZE{l_next[SIZE-1]}});
        end else begin
            ovf_next = ({h_next[SIZE-3:0], l_next[EW-1:SIZE]} != '0);
        end
    end

    // Overflow flag registered alongside the product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signed_res_q <= 1'b0;
            ovf          <= 1'b0;
        end else if (accept) begin
            signed_res_q <= (mode_in != MODE_UU);
        end else if ((state == BUSY) && last_step) begin
            ovf <= ovf_next;
        end
    end
`endif

endmodule

// File: tb/tb_multiplier_seq_msu.sv
// Self-checking bench for multiplier_seq_msu at SIZE=8 (five Booth steps).
// Honours macro MULTIPLIER_SEQ_OVF_EN to also check the overflow flag.
module tb_multiplier_seq_msu;

    localparam int SIZE    = 8;
    localparam int LATENCY = SIZE / 2 + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [SIZE-1:0]   a, b;
    logic              sign, mix;
    logic              out_valid;
    logic              out_ready;
    logic [2*SIZE-1:0] y;
    logic              busy;
`ifdef MULTIPLIER_SEQ_OVF_EN
    logic              ovf;
`endif

    int check_count = 0;
    int fail_count  = 0;

    multiplier_seq_msu #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sign      (sign),
        .mix       (mix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
`ifdef MULTIPLIER_SEQ_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Exact product from plain integer arithmetic on the interpreted operands
    function automatic longint ref_value(input logic [SIZE-1:0] av, input logic [SIZE-1:0] bv,
                                         input logic s, input logic m);
        longint x, z;
        if (s || m) x = longint'($signed(av));
        else        x = longint'(av);
        if (s)      z = longint'($signed(bv));
        else        z = longint'(bv);
        return x * z;
    endfunction

    function automatic logic ref_ovf(input longint p, input logic s, input logic m);
        if (s || m) return (p < -(64'sd1 << (SIZE - 1))) || (p > ((64'sd1 << (SIZE - 1)) - 1));
        return p > ((64'sd1 << SIZE) - 1);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic accept_op(input logic [SIZE-1:0] av, input logic [SIZE-1:0] bv, input logic s, input logic m);
        a = av; b = bv; sign = s; mix = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = SIZE'($urandom); b = SIZE'($urandom); sign = 1'($urandom); mix = 1'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 4 * LATENCY) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_result(input string tag, input logic [SIZE-1:0] av, input logic [SIZE-1:0] bv,
                                input logic s, input logic m);
        longint p;
        p = ref_value(av, bv, s, m);
        check_output({tag, "_y"}, 32'(y), 32'(p[2*SIZE-1:0]));
`ifdef MULTIPLIER_SEQ_OVF_EN
        check_output({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(p, s, m)));
`endif
    endtask

    task automatic apply_stimulus(input string tag, input logic [SIZE-1:0] av, input logic [SIZE-1:0] bv,
                                  input logic s, input logic m);
        int n;
        accept_op(av, bv, s, m);
        check_output({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(n);
        check_output({tag, "_latency"}, 32'(n), 32'(LATENCY));
        check_result(tag, av, bv, s, m);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_output({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n;
        logic seen_valid;
        logic [2*SIZE-1:0] held_y;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sign = 1'b0; mix = 1'b0;
        #1;
        $display("[TB] reset state");
        check_output("rst_in_ready", 32'(in_ready), 32'd0);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_y", 32'(y), 32'd0);
`ifdef MULTIPLIER_SEQ_OVF_EN
        check_output("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_output("rel_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] directed corner products");
        apply_stimulus("uu_ff_ff", 8'hFF, 8'hFF, 1'b0, 1'b0);
        check_output("uu_ff_ff_const", 32'(y), 32'h0000FE01);
        apply_stimulus("ss_min_min", 8'h80, 8'h80, 1'b1, 1'b0);
        check_output("ss_min_min_const", 32'(y), 32'h00004000);
        apply_stimulus("ss_min_max", 8'h80, 8'h7F, 1'b1, 1'b1);
        check_output("ss_min_max_const", 32'(y), 32'h0000C080);
        apply_stimulus("su_ff_ff", 8'hFF, 8'hFF, 1'b0, 1'b1);
        check_output("su_ff_ff_const", 32'(y), 32'h0000FF01);
        apply_stimulus("uu_zero", 8'h00, 8'hA5, 1'b0, 1'b0);
        apply_stimulus("su_min_ff", 8'h80, 8'hFF, 1'b0, 1'b1);

        $display("[TB] stall in DONE then back-to-back accept");
        accept_op(8'h12, 8'h34, 1'b0, 1'b0);
        in_valid = 1'b1;
        check_output("b2b_busy_no_ready", 32'(in_ready), 32'd0);
        wait_done(n);
        check_output("b2b_latency1", 32'(n), 32'(LATENCY));
        held_y = y;
        check_result("b2b_first", 8'h12, 8'h34, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_output("stall_y", 32'(y), 32'(held_y));
            check_output("stall_valid", 32'(out_valid), 32'd1);
        end
        a = 8'hC3; b = 8'h5A; sign = 1'b1; mix = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        a = 8'h00; b = 8'h00; sign = 1'b0;
        check_output("b2b_busy", 32'(busy), 32'd1);
        check_output("b2b_no_valid", 32'(out_valid), 32'd0);
        wait_done(n);
        check_output("b2b_latency2", 32'(n), 32'(LATENCY));
        check_result("b2b_second", 8'hC3, 8'h5A, 1'b1, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        $display("[TB] reset during BUSY");
        accept_op(8'h55, 8'h66, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_output("midrst_y", 32'(y), 32'd0);
        check_output("midrst_valid", 32'(out_valid), 32'd0);
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_output("midrst_rel_ready", 32'(in_ready), 32'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < 3 * LATENCY; i++) begin
            seen_valid = seen_valid | out_valid;
            @(posedge clk); #1;
        end
        check_output("midrst_no_valid", 32'(seen_valid), 32'd0);

        $display("[TB] random sweep");
        for (int i = 0; i < 1500; i++) begin
            apply_stimulus("rand", SIZE'($urandom), SIZE'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
